// File: rtl/cv32e40p_ft_pkg.sv
// Shared types for the TMR fault-tolerance manager: command opcodes, FSM states
// and a 3-bit population count used for replica-health checks.
package cv32e40p_ft_pkg;

  typedef enum logic [1:0] {
    NOP     = 2'd0,
    FORCE   = 2'd1,
    RELEASE = 2'd2,
    CLR_CNT = 2'd3
  } ft_cmd_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } ft_mgr_state_e;

  function automatic logic [1:0] popcnt3(input logic [2:0] v);
    return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
  endfunction

endpackage

// File: rtl/cv32e40p_ft_err_counter.sv
// Per-unit saturating error counter with a sticky threshold flag; a clear that
// coincides with an increment restarts the count at 1.
module cv32e40p_ft_err_counter #(
  parameter int CNT_W      = 8,
  parameter int IRQ_THRESH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             irq_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             irq_d, irq_q;

  always_comb begin
    cnt_d = cnt_q;
    irq_d = irq_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
      irq_d = 1'b0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (32'(cnt_d) >= IRQ_THRESH) irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign cnt_o = cnt_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/cv32e40p_ft_manager.sv
// Central TMR maintenance controller: sequences force/release/clear commands
// against each unit's set_broken/is_broken loop and tracks error statistics.
module cv32e40p_ft_manager
  import cv32e40p_ft_pkg::*;
#(
  parameter int NBLOCKS     = 4,
  parameter int CNT_W       = 8,
  parameter int IRQ_THRESH  = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int BLK_W       = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NBLOCKS*3-1:0] is_broken_i,
  input  logic [NBLOCKS-1:0]   err_detected_i,
  output logic [NBLOCKS*3-1:0] set_broken_o,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [1:0]           cmd_op_i,
  input  logic [BLK_W-1:0]     cmd_blk_i,
  input  logic [1:0]           cmd_rep_i,
  output logic                 resp_valid_o,
  output logic                 resp_err_o,
  input  logic [BLK_W-1:0]     rd_blk_i,
  output logic [CNT_W-1:0]     rd_cnt_o,
  output logic                 irq_o,
  output logic                 fatal_o
);

  localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  ft_mgr_state_e        state_d, state_q;
  ft_cmd_e              op_d, op_q;
  logic [BLK_W-1:0]     blk_d, blk_q;
  logic [1:0]           rep_d, rep_q;
  logic [NBLOCKS*3-1:0] mask_d, mask_q;
  logic [TMR_W-1:0]     timer_d, timer_q;
  logic                 resp_valid_d, resp_valid_q;
  logic                 resp_err_d, resp_err_q;
  logic                 fatal_d, fatal_q;

  logic [2:0]           ib_arr   [NBLOCKS];
  logic [2:0]           mask_arr [NBLOCKS];
  logic [CNT_W-1:0]     cnt_arr  [NBLOCKS];
  logic [NBLOCKS-1:0]   irq_vec, clr_vec, unit_fatal;
  logic [NBLOCKS*3-1:0] sel_bit;
  logic                 clr_en, legal, cur_mask, cur_ib;
  logic [2:0]           unit_ib, unit_mask, rep_oh;
  logic [1:0]           healthy_after;

  for (genvar gi = 0; gi < NBLOCKS; gi++) begin : g_unit
    assign ib_arr[gi]     = is_broken_i[3*gi +: 3];
    assign mask_arr[gi]   = mask_q[3*gi +: 3];
    assign unit_fatal[gi] = popcnt3(ib_arr[gi]) >= 2'd2;
    assign clr_vec[gi]    = clr_en && (blk_q == BLK_W'(gi));
    for (genvar gr = 0; gr < 3; gr++) begin : g_rep
      assign sel_bit[3*gi+gr] = (blk_q == BLK_W'(gi)) && (rep_q == 2'(gr));
    end
    cv32e40p_ft_err_counter #(
      .CNT_W      (CNT_W),
      .IRQ_THRESH (IRQ_THRESH)
    ) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (err_detected_i[gi]),
      .clr_i (clr_vec[gi]),
      .cnt_o (cnt_arr[gi]),
      .irq_o (irq_vec[gi])
    );
  end

  assign legal     = (32'(blk_q) < NBLOCKS) && (rep_q != 2'd3);
  assign unit_ib   = legal ? ib_arr[blk_q] : 3'b000;
  assign unit_mask = legal ? mask_arr[blk_q] : 3'b000;
  assign rep_oh    = 3'b001 << rep_q;
  assign cur_mask  = |(mask_q & sel_bit);
  assign cur_ib    = |(is_broken_i & sel_bit);
  // Replicas left healthy (neither broken nor forced) if this force went ahead.
  assign healthy_after = popcnt3(~(unit_ib | unit_mask | rep_oh));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    blk_d      = blk_q;
    rep_d      = rep_q;
    mask_d     = mask_q;
    timer_d    = timer_q;
    resp_err_d = 1'b0;
    clr_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          op_d    = ft_cmd_e'(cmd_op_i);
          blk_d   = cmd_blk_i;
          rep_d   = cmd_rep_i;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = RESP;
        if (op_q == NOP) begin
          resp_err_d = 1'b0;
        end else if (!legal) begin
          resp_err_d = 1'b1;
        end else begin
          unique case (op_q)
            FORCE: begin
              if (cur_mask || (healthy_after < 2'd2)) begin
                resp_err_d = 1'b1;
              end else begin
                mask_d  = mask_q | sel_bit;
                timer_d = '0;
                state_d = WAIT;
              end
            end
            RELEASE: begin
              if (cur_mask) begin
                mask_d  = mask_q & ~sel_bit;
                timer_d = '0;
                state_d = WAIT;
              end
            end
            CLR_CNT: clr_en = 1'b1;
            default: ;
          endcase
        end
      end
      WAIT: begin
        if (cur_ib == cur_mask) begin
          state_d = RESP;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d    = RESP;
          resp_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
    fatal_d      = fatal_q | (|unit_fatal);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      op_q         <= NOP;
      blk_q        <= '0;
      rep_q        <= '0;
      mask_q       <= '0;
      timer_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      fatal_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      blk_q        <= blk_d;
      rep_q        <= rep_d;
      mask_q       <= mask_d;
      timer_q      <= timer_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      fatal_q      <= fatal_d;
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign set_broken_o = mask_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign fatal_o      = fatal_q;
  assign irq_o        = |irq_vec;
  assign rd_cnt_o     = (32'(rd_blk_i) < NBLOCKS) ? cnt_arr[rd_blk_i] : '0;

endmodule
